clk_ratio_monitor: RTL

- Receive-side checker for divided clocks. It takes a slow clock (for example the odd/even divider output) as a plain data signal and samples it in the fast `clk` domain.
- Measures period and high time in `clk` cycles and asserts lock once the measured ratio matches the expected ratio.
- Flags loss of the divided clock.
- Sits next to clock dividers on bring-up and in self-test paths; its output is status only and is never used as a clock.

---
 rtl/clk_ratio_monitor_pkg.sv | 21 ++
 rtl/clk_ratio_monitor_sync_edge_det.sv | 42 ++++
 rtl/clk_ratio_monitor.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_ratio_monitor_pkg.sv
// Shared types and helpers for the divided-clock ratio monitor.
// Holds the monitor FSM state encoding, the counter-width helper and the
// default synchronizer depth used by sync_edge_det.
package clk_mon_pkg;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Default number of synchronizer flops for an asynchronous level input.
  localparam int DEF_SYNC_STAGES = 2;

  // Width needed to hold a counter that saturates at max_period.
  function automatic int cnt_w(input int max_period);
    return $clog2(max_period + 1);
  endfunction

endpackage

// File: rtl/clk_ratio_monitor_sync_edge_det.sv
// sync_edge_det: brings an asynchronous level into the clk domain through
// STAGES flops, keeps one extra delay flop, and reports the synchronized
// level plus a one-cycle rising-edge strobe (level=1 while delayed=0).
// Reusable by any monitor that watches a slow asynchronous toggle.
module sync_edge_det
  import clk_mon_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              dly_q;
  logic              dly_d;

  // Shift the raw input into the synchronizer chain; delay flop trails the last stage.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    dly_d  = sync_q[STAGES-1];
  end

  // Synchronizer and delay registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor: samples a divided clock as data in the fast clk domain,
// measures its period and high time in clk cycles, asserts locked after
// LOCK_CNT consecutive in-tolerance periods and raises a sticky clk_lost
// flag when no rising edge arrives within MAX_PERIOD cycles.
// Status only: nothing here is ever used as a clock.
// Optional build macro CLK_RATIO_MONITOR_DUTY_CHECK_EN adds a duty-cycle
// check and the duty_err output; without it lock depends on period alone.
module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXP_RATIO   = 5,
  parameter int TOL         = 1,
  parameter int LOCK_CNT    = 4,
  parameter int MAX_PERIOD  = 64,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = cnt_w(MAX_PERIOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             clk_lost
`ifdef CLK_RATIO_MONITOR_DUTY_CHECK_EN
  ,
  output logic             duty_err
`endif
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [MW-1:0]    LOCK_M  = MW'(LOCK_CNT);
  localparam logic [MW-1:0]    LOCK_M1 = MW'(LOCK_CNT - 1);

  localparam logic signed [CNT_W+1:0] EXP_S = (CNT_W+2)'(EXP_RATIO);
  localparam logic signed [CNT_W+1:0] TOL_S = (CNT_W+2)'(TOL);

  // Counter step that sticks at MAX_PERIOD instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= MAX_C) ? MAX_C : v + 1'b1;
  endfunction

  // True when the measured period is within +/-TOL of EXP_RATIO.
  function automatic logic period_ok(input logic [CNT_W-1:0] p);
    logic signed [CNT_W+1:0] diff;
    diff = $signed({2'b00, p}) - EXP_S;
    return (diff >= -TOL_S) && (diff <= TOL_S);
  endfunction

`ifdef CLK_RATIO_MONITOR_DUTY_CHECK_EN
  // True when high time lies in [p/2 - TOL, (p+1)/2 + TOL], integer halves.
  function automatic logic duty_ok(input logic [CNT_W-1:0] p,
                                   input logic [CNT_W-1:0] h);
    logic        [CNT_W+1:0] p_inc;
    logic signed [CNT_W+1:0] lo;
    logic signed [CNT_W+1:0] hi;
    logic signed [CNT_W+1:0] h_s;
    p_inc = {2'b00, p} + 1'b1;
    lo    = $signed({3'b000, p[CNT_W-1:1]}) - TOL_S;
    hi    = $signed({1'b0, p_inc[CNT_W+1:1]}) + TOL_S;
    h_s   = $signed({2'b00, h});
    return (h_s >= lo) && (h_s <= hi);
  endfunction
`endif

  logic rise;
  logic level;

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] per_cnt_q,    per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q,     hi_cnt_d;
  logic [MW-1:0]    match_cnt_q,  match_cnt_d;
  logic [CNT_W-1:0] period_q,     period_d;
  logic [CNT_W-1:0] high_time_q,  high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q,     locked_d;
  logic             clk_lost_q,   clk_lost_d;
  logic             match_ok;
`ifdef CLK_RATIO_MONITOR_DUTY_CHECK_EN
  logic             duty_err_q,   duty_err_d;
  logic             duty_bad;
`endif

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (clk_in),
    .level (level),
    .rise  (rise)
  );

  // Next-state logic: counting, measurement capture, lock tracking and timeout.
  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    match_cnt_d  = match_cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    clk_lost_d   = clk_lost_q;
    match_ok     = 1'b0;
`ifdef CLK_RATIO_MONITOR_DUTY_CHECK_EN
    duty_err_d   = duty_err_q;
    duty_bad     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Counters stay parked until the first edge; that edge only starts a period.
        per_cnt_d = '0;
        hi_cnt_d  = '0;
        if (rise) begin
          per_cnt_d  = ONE_C;
          hi_cnt_d   = ONE_C;
          clk_lost_d = 1'b0;
          state_d    = MEASURE;
        end
      end

      MEASURE, LOCKED: begin
        if (rise) begin
          // Close the running period; the edge cycle itself opens the next one as high.
          period_d     = per_cnt_q;
          high_time_d  = hi_cnt_q;
          meas_valid_d = 1'b1;
          per_cnt_d    = ONE_C;
          hi_cnt_d     = ONE_C;
          match_ok     = period_ok(per_cnt_q);
`ifdef CLK_RATIO_MONITOR_DUTY_CHECK_EN
          duty_bad     = !duty_ok(per_cnt_q, hi_cnt_q);
          duty_err_d   = duty_bad;
          match_ok     = match_ok && !duty_bad;
`endif
          if (match_ok) begin
            if (match_cnt_q >= LOCK_M1) begin
              match_cnt_d = LOCK_M;
              locked_d    = 1'b1;
              state_d     = LOCKED;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            match_cnt_d = '0;
            locked_d    = 1'b0;
            state_d     = MEASURE;
          end
        end else if (per_cnt_q >= MAX_M1) begin
          // Counter would reach MAX_PERIOD with no edge: declare the clock lost.
          per_cnt_d   = '0;
          hi_cnt_d    = '0;
          match_cnt_d = '0;
          locked_d    = 1'b0;
          clk_lost_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          per_cnt_d = sat_inc(per_cnt_q);
          if (level) begin
            hi_cnt_d = sat_inc(hi_cnt_q);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      match_cnt_q  <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      clk_lost_q   <= 1'b0;
`ifdef CLK_RATIO_MONITOR_DUTY_CHECK_EN
      duty_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      match_cnt_q  <= match_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      clk_lost_q   <= clk_lost_d;
`ifdef CLK_RATIO_MONITOR_DUTY_CHECK_EN
      duty_err_q   <= duty_err_d;
`endif
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign clk_lost   = clk_lost_q;
`ifdef CLK_RATIO_MONITOR_DUTY_CHECK_EN
  assign duty_err   = duty_err_q;
`endif

endmodule
